kf8253_bus_sequencer: RTL



---
 rtl/kf8253_seq_pkg.sv | 32 +++
 rtl/kf8253_bus_sequencer_if.sv | 39 +++
 rtl/kf8253_bus_cycle.sv | 121 ++++++++++++
 rtl/kf8253_bus_sequencer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/kf8253_seq_pkg.sv
// Shared types and constants for the KF8253 bus sequencer: access FSM states,
// access phases and 8253 control-word / address encodings.
package kf8253_seq_pkg;

  typedef enum logic [2:0] {
    ACC_IDLE,
    ACC_SETUP,
    ACC_STROBE,
    ACC_HOLD,
    ACC_GAP
  } access_state_e;

  typedef enum logic [1:0] {
    PH_CTRL,
    PH_LSB,
    PH_MSB
  } phase_e;

  localparam logic [1:0] RW_LATCH   = 2'b00;
  localparam logic [1:0] RW_LSB_MSB = 2'b11;

  localparam logic [1:0] PIT_ADDR_CONTROL = 2'd3;
  localparam logic [1:0] COUNTER_ILLEGAL  = 2'd3;

  function automatic logic [7:0] control_word(input logic [1:0] counter,
                                              input logic [1:0] rw,
                                              input logic [2:0] mode,
                                              input logic       bcd);
    return {counter, rw, mode, bcd};
  endfunction

endpackage

// File: rtl/kf8253_bus_sequencer_if.sv
// Command/response channel plus the 8253 CPU-side pins driven by the sequencer.
interface kf8253_bus_sequencer_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_read;
  logic [1:0]  cmd_counter;
  logic [2:0]  cmd_mode;
  logic        cmd_bcd;
  logic [15:0] cmd_count;

  logic        rsp_valid;
  logic        rsp_error;
  logic [15:0] rsp_data;

  logic        pit_chip_select_n;
  logic        pit_read_enable_n;
  logic        pit_write_enable_n;
  logic [1:0]  pit_address;
  logic [7:0]  pit_data_out;
  logic [7:0]  pit_data_in;

  modport master (
    output cmd_valid, cmd_read, cmd_counter, cmd_mode, cmd_bcd, cmd_count,
    input  cmd_ready, rsp_valid, rsp_error, rsp_data,
    input  pit_chip_select_n, pit_read_enable_n, pit_write_enable_n,
    input  pit_address, pit_data_out,
    output pit_data_in
  );

  modport slave (
    input  cmd_valid, cmd_read, cmd_counter, cmd_mode, cmd_bcd, cmd_count,
    output cmd_ready, rsp_valid, rsp_error, rsp_data,
    output pit_chip_select_n, pit_read_enable_n, pit_write_enable_n,
    output pit_address, pit_data_out,
    input  pit_data_in
  );

endinterface

// File: rtl/kf8253_bus_cycle.sv
// Single 8253 bus access engine: SETUP -> STROBE x N -> HOLD -> GAP, with all
// pins registered so they change only on clock edges (or asynchronously on reset).
module kf8253_bus_cycle
  import kf8253_seq_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_i,
  input  logic       is_read_i,
  input  logic [1:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic       done_o,
  output logic [7:0] rdata_o,
  output logic       pit_chip_select_n_o,
  output logic       pit_read_enable_n_o,
  output logic       pit_write_enable_n_o,
  output logic [1:0] pit_address_o,
  output logic [7:0] pit_data_out_o,
  input  logic [7:0] pit_data_in_i
);

  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

  access_state_e state_q, state_d;
  logic [3:0]    strobe_cnt_q, strobe_cnt_d;
  logic          is_read_q, is_read_d;
  logic          cs_n_q, cs_n_d;
  logic          rd_n_q, rd_n_d;
  logic          wr_n_q, wr_n_d;
  logic [1:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    rdata_q, rdata_d;

  // NOTE: state uses non-blocking assignments and an asynchronous reset, so
  // strobes and chip select go inactive the instant reset rises.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ACC_IDLE;
      strobe_cnt_q <= '0;
      is_read_q    <= 1'b0;
      cs_n_q       <= 1'b1;
      rd_n_q       <= 1'b1;
      wr_n_q       <= 1'b1;
      addr_q       <= '0;
      data_q       <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      strobe_cnt_q <= strobe_cnt_d;
      is_read_q    <= is_read_d;
      cs_n_q       <= cs_n_d;
      rd_n_q       <= rd_n_d;
      wr_n_q       <= wr_n_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      rdata_q      <= rdata_d;
    end
  end

  // Each branch computes the pin values for the state being entered.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d      = state_q;
    strobe_cnt_d = strobe_cnt_q;
    is_read_d    = is_read_q;
    cs_n_d       = 1'b1;
    rd_n_d       = 1'b1;
    wr_n_d       = 1'b1;
    addr_d       = addr_q;
    data_d       = data_q;
    rdata_d      = rdata_q;

    case (state_q)
      ACC_IDLE, ACC_GAP: begin
        if (start_i) begin
          state_d   = ACC_SETUP;
          is_read_d = is_read_i;
          cs_n_d    = 1'b0;
          addr_d    = addr_i;
          data_d    = is_read_i ? 8'h00 : wdata_i;
        end else begin
          state_d = ACC_IDLE;
        end
      end
      ACC_SETUP: begin
        state_d      = ACC_STROBE;
        strobe_cnt_d = STROBE_LAST;
        cs_n_d       = 1'b0;
        rd_n_d       = ~is_read_q;
        wr_n_d       = is_read_q;
      end
      ACC_STROBE: begin
        cs_n_d = 1'b0;
        if (strobe_cnt_q == 4'd0) begin
          state_d = ACC_HOLD;
          if (is_read_q) rdata_d = pit_data_in_i;
        end else begin
          strobe_cnt_d = strobe_cnt_q - 4'd1;
          rd_n_d       = ~is_read_q;
          wr_n_d       = is_read_q;
        end
      end
      ACC_HOLD: begin
        state_d = ACC_GAP;
        data_d  = 8'h00;
      end
      default: state_d = ACC_IDLE;
    endcase
  end

  assign done_o               = (state_q == ACC_GAP);
  assign rdata_o              = rdata_q;
  assign pit_chip_select_n_o  = cs_n_q;
  assign pit_read_enable_n_o  = rd_n_q;
  assign pit_write_enable_n_o = wr_n_q;
  assign pit_address_o        = addr_q;
  assign pit_data_out_o       = data_q;

endmodule

// File: rtl/kf8253_bus_sequencer.sv
// Command-driven 8253 bus master: expands one program/read command into the
// control-word, LSB and MSB accesses and returns a single response pulse.
module kf8253_bus_sequencer
  import kf8253_seq_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  kf8253_bus_sequencer_if.slave  bus
);

  logic        ready_q, ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_error_q, rsp_error_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  phase_e      phase_q, phase_d;
  logic        read_q, read_d;
  logic [1:0]  counter_q, counter_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  lsb_q, lsb_d;

  logic       accept;
  logic       eng_start;
  logic       eng_read;
  logic [1:0] eng_addr;
  logic [7:0] eng_wdata;
  logic       eng_done;
  logic [7:0] eng_rdata;

  assign accept = bus.cmd_valid && ready_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_data_q  <= '0;
      phase_q     <= PH_CTRL;
      read_q      <= 1'b0;
      counter_q   <= '0;
      count_q     <= '0;
      lsb_q       <= '0;
    end else begin
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_data_q  <= rsp_data_d;
      phase_q     <= phase_d;
      read_q      <= read_d;
      counter_q   <= counter_d;
      count_q     <= count_d;
      lsb_q       <= lsb_d;
    end
  end

  // Phase 0 is launched straight from the command inputs so its SETUP lands
  // one cycle after acceptance; later phases use the captured fields.
  always_comb begin
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    rsp_error_d = rsp_error_q;
    rsp_data_d  = rsp_data_q;
    phase_d     = phase_q;
    read_d      = read_q;
    counter_d   = counter_q;
    count_d     = count_q;
    lsb_d       = lsb_q;
    eng_start   = 1'b0;
    eng_read    = read_q;
    eng_addr    = counter_q;
    eng_wdata   = 8'h00;

    if (accept) begin
      read_d    = bus.cmd_read;
      counter_d = bus.cmd_counter;
      count_d   = bus.cmd_count;
      if (bus.cmd_counter == COUNTER_ILLEGAL) begin
        rsp_valid_d = 1'b1;
        rsp_error_d = 1'b1;
        rsp_data_d  = '0;
      end else begin
        ready_d   = 1'b0;
        phase_d   = PH_CTRL;
        eng_start = 1'b1;
        eng_read  = 1'b0;
        eng_addr  = PIT_ADDR_CONTROL;
        eng_wdata = bus.cmd_read
                  ? control_word(bus.cmd_counter, RW_LATCH, 3'b000, 1'b0)
                  : control_word(bus.cmd_counter, RW_LSB_MSB, bus.cmd_mode, bus.cmd_bcd);
      end
    end else if (eng_done) begin
      case (phase_q)
        PH_CTRL: begin
          phase_d   = PH_LSB;
          eng_start = 1'b1;
          eng_wdata = count_q[7:0];
        end
        PH_LSB: begin
          lsb_d     = eng_rdata;
          phase_d   = PH_MSB;
          eng_start = 1'b1;
          eng_wdata = count_q[15:8];
        end
        default: begin
          phase_d     = PH_CTRL;
          ready_d     = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b0;
          rsp_data_d  = read_q ? {eng_rdata, lsb_q} : 16'h0000;
        end
      endcase
    end
  end

  kf8253_bus_cycle #(
    .STROBE_CYCLES (STROBE_CYCLES)
  ) u_bus_cycle (
    .clock                (clock),
    .reset                (reset),
    .start_i              (eng_start),
    .is_read_i            (eng_read),
    .addr_i               (eng_addr),
    .wdata_i              (eng_wdata),
    .done_o               (eng_done),
    .rdata_o              (eng_rdata),
    .pit_chip_select_n_o  (bus.pit_chip_select_n),
    .pit_read_enable_n_o  (bus.pit_read_enable_n),
    .pit_write_enable_n_o (bus.pit_write_enable_n),
    .pit_address_o        (bus.pit_address),
    .pit_data_out_o       (bus.pit_data_out),
    .pit_data_in_i        (bus.pit_data_in)
  );

  assign bus.cmd_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_error = rsp_error_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule
